// File: rtl/entry_pkg.sv
// Shared types and defaults for the front-panel number entry block.
package entry_pkg;

    // One decimal digit in BCD form.
    typedef logic [3:0] bcd_t;

    // Entry FSM states.
    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } entry_state_t;

    localparam int DIGITS_DEF   = 6;
    localparam int VALUE_W_DEF  = 20;
    localparam int DEBOUNCE_DEF = 4096;

    // Decimal increment of one digit, 9 wraps back to 0.
    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push key: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle press pulse on a debounced release->press transition.
module key_debounce
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Synchronizer idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has been stable for the full window.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = level_q & ~level_d;
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/key_number_entry.sv
// Front-panel decimal entry: two keys edit a BCD number digit by digit,
// a commit converts it to binary sequentially (MSD first, shift-add x10)
// and presents the result with a one-cycle valid strobe.
module key_number_entry
    import entry_pkg::*;
#(
    parameter int DIGITS          = DIGITS_DEF,
    parameter int VALUE_W         = VALUE_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            key_n,
    input  logic                  mode_sw,
    output logic [DIGITS*4-1:0]   digits,
    output logic [2:0]            cursor,
    output logic [VALUE_W-1:0]    value,
    output logic                  value_valid,
    output logic                  busy
);

    localparam int CUR_W = 3;
    localparam logic [CUR_W-1:0] CUR_MAX = CUR_W'(DIGITS - 1);

    logic [1:0]         press;
    logic               mode_s1_q;
    logic               mode_s2_q;

    entry_state_t       state_q;
    entry_state_t       state_d;
    bcd_t               digits_q [DIGITS];
    bcd_t               digits_d [DIGITS];
    logic [CUR_W-1:0]   cursor_q;
    logic [CUR_W-1:0]   cursor_d;
    logic [CUR_W-1:0]   conv_idx_q;
    logic [CUR_W-1:0]   conv_idx_d;
    logic [VALUE_W-1:0] acc_q;
    logic [VALUE_W-1:0] acc_d;
    logic [VALUE_W-1:0] value_q;
    logic [VALUE_W-1:0] value_d;
    logic               value_valid_q;
    logic               value_valid_d;

    // One debouncer per key.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .raw_n (key_n[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // mode_sw is a slide switch: synchronized only, no debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
        end else begin
            mode_s1_q <= mode_sw;
            mode_s2_q <= mode_s1_q;
        end
    end

    // Next-state logic: editing, commit/clear, and the shift-add converter.
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        conv_idx_d    = conv_idx_q;
        acc_d         = acc_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digits_d[i] = digits_q[i];
        end

        case (state_q)
            EDIT: begin
                if (!mode_s2_q) begin
                    // Increment uses the old cursor even if it advances now.
                    if (press[0]) begin
                        digits_d[cursor_q] = bcd_inc(digits_q[cursor_q]);
                    end
                    if (press[1]) begin
                        cursor_d = (cursor_q == CUR_MAX) ? '0 : cursor_q + 1'b1;
                    end
                end else begin
                    // Clear takes priority over commit when both arrive together.
                    if (press[1]) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            digits_d[i] = '0;
                        end
                        cursor_d = '0;
                    end else if (press[0]) begin
                        state_d    = CONVERT;
                        acc_d      = '0;
                        conv_idx_d = CUR_MAX;
                    end
                end
            end

            CONVERT: begin
                // acc*10 as (acc<<3)+(acc<<1); digits are frozen meanwhile.
                acc_d = (acc_q << 3) + (acc_q << 1)
                        + VALUE_W'(digits_q[conv_idx_q]);
                conv_idx_d = conv_idx_q - 1'b1;
                if (conv_idx_q == '0) begin
                    // Result and strobe land together in the DONE cycle.
                    state_d       = DONE;
                    value_d       = acc_d;
                    value_valid_d = 1'b1;
                end
            end

            DONE: begin
                state_d = EDIT;
            end

            default: begin
                state_d = EDIT;
            end
        endcase
    end

    // State, digit file, converter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EDIT;
            cursor_q      <= '0;
            conv_idx_q    <= '0;
            acc_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                digits_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            conv_idx_q    <= conv_idx_d;
            acc_q         <= acc_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            for (int i = 0; i < DIGITS; i++) begin
                digits_q[i] <= digits_d[i];
            end
        end
    end

    // Pack the digit file for the display, digit i at [4i+3:4i].
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pack
            assign digits[4*gi +: 4] = digits_q[gi];
        end
    endgenerate

    assign cursor      = cursor_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign busy        = (state_q == CONVERT);

endmodule

// File: tb/tb_key_number_entry.sv
// Scenario bench for key_number_entry with a short debounce window.
module tb_key_number_entry;

    localparam int DIGITS  = 6;
    localparam int VALUE_W = 20;
    localparam int DEB     = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            key_n = 2'b11;
    logic                  mode_sw = 1'b0;
    logic [DIGITS*4-1:0]   digits;
    logic [2:0]            cursor;
    logic [VALUE_W-1:0]    value;
    logic                  value_valid;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;
    int busy_run    = 0;
    logic [VALUE_W-1:0] sb [$];

    always #5 clk = ~clk;

    key_number_entry #(
        .DIGITS          (DIGITS),
        .VALUE_W         (VALUE_W),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .mode_sw     (mode_sw),
        .digits      (digits),
        .cursor      (cursor),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy)
    );

    function automatic logic [DIGITS*4-1:0] to_bcd(input int n);
        logic [DIGITS*4-1:0] r;
        int v;
        v = n;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Advance one cycle; score any value_valid pulse and each busy window.
    task automatic tick();
        logic [VALUE_W-1:0] exp_v;
        @(negedge clk);
        if (value_valid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_valid: value_valid=1 value=%0d, no pulse expected", value);
            end else begin
                exp_v = sb.pop_front();
                $display("result: value=%0d expected=%0d", value, exp_v);
                if (value !== exp_v) begin
                    miscompares++;
                    $display("FAIL commit_value: got %0d, expected %0d", value, exp_v);
                end
            end
        end
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            vectors++;
            if (busy_run != DIGITS || value_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_window: busy cycles=%0d valid_after=%b, expected %0d and 1",
                         busy_run, value_valid, DIGITS);
            end
            busy_run = 0;
        end
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        repeat (10) tick();
        key_n[k] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic press_both();
        key_n = 2'b00;
        repeat (10) tick();
        key_n = 2'b11;
        repeat (10) tick();
    endtask

    task automatic set_mode(input logic m);
        mode_sw = m;
        repeat (4) tick();
    endtask

    // Assumes all digits zero and cursor 0; leaves cursor back at 0.
    task automatic enter_number(input int n);
        int v;
        v = n;
        for (int i = 0; i < DIGITS; i++) begin
            repeat (v % 10) press(0);
            press(1);
            v = v / 10;
        end
    endtask

    task automatic clear_all();
        set_mode(1'b1);
        press(1);
        set_mode(1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d results still pending, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if (digits !== '0 || cursor !== 3'd0 || value !== '0 || busy !== 1'b0 || value_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: digits=%h cursor=%0d value=%0d busy=%b valid=%b, expected all 0",
                     digits, cursor, value, busy, value_valid);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        vectors++;
        if (digits !== '0 || cursor !== 3'd0 || value !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: digits=%h cursor=%0d value=%0d busy=%b, expected all 0",
                     digits, cursor, value, busy);
        end
        $display("reset: digits=%h cursor=%0d value=%0d", digits, cursor, value);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            key_n[0] = ~key_n[0];
            repeat (2) tick();
        end
        key_n[0] = 1'b0;
        repeat (10) tick();
        key_n[0] = 1'b1;
        repeat (10) tick();
        vectors++;
        $display("bounce: digits=%h cursor=%0d", digits, cursor);
        if (digits !== to_bcd(1) || cursor !== 3'd0) begin
            miscompares++;
            $display("FAIL bounce: digits=%h cursor=%0d, expected %h and 0", digits, cursor, to_bcd(1));
        end
    endtask

    task automatic test_edit_wrap();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 1; i <= 10; i++) begin
            press(0);
            vectors++;
            $display("inc %0d: digits=%h", i, digits);
            if (digits !== to_bcd(i % 10)) begin
                miscompares++;
                $display("FAIL digit_inc: press %0d digits=%h, expected %h", i, digits, to_bcd(i % 10));
            end
        end
        for (int i = 1; i <= DIGITS; i++) begin
            press(1);
            vectors++;
            $display("cursor %0d: cursor=%0d", i, cursor);
            if (cursor !== 3'(i % DIGITS)) begin
                miscompares++;
                $display("FAIL cursor_inc: press %0d cursor=%0d, expected %0d", i, cursor, i % DIGITS);
            end
        end
    endtask

    task automatic test_commit();
        enter_number(123456);
        vectors++;
        if (digits !== to_bcd(123456) || cursor !== 3'd0) begin
            miscompares++;
            $display("FAIL enter_123456: digits=%h cursor=%0d, expected %h and 0",
                     digits, cursor, to_bcd(123456));
        end
        set_mode(1'b1);
        sb.push_back(20'd123456);
        press(0);
        wait_drain("commit");
        vectors++;
        if (value !== 20'h1E240) begin
            miscompares++;
            $display("FAIL commit_hold: value=%h, expected 1e240", value);
        end
    endtask

    task automatic test_press_during_busy();
        sb.push_back(20'd123456);
        key_n[0] = 1'b0;
        repeat (3) tick();
        key_n[1] = 1'b0;
        repeat (10) tick();
        key_n = 2'b11;
        repeat (10) tick();
        wait_drain("busy_press");
        vectors++;
        $display("busy press: digits=%h cursor=%0d value=%0d", digits, cursor, value);
        if (digits !== to_bcd(123456) || cursor !== 3'd0) begin
            miscompares++;
            $display("FAIL busy_discard: digits=%h cursor=%0d, expected %h and 0",
                     digits, cursor, to_bcd(123456));
        end
    endtask

    task automatic test_simultaneous();
        press_both();
        vectors++;
        $display("both cmd: digits=%h cursor=%0d value=%0d", digits, cursor, value);
        if (digits !== '0 || cursor !== 3'd0 || value !== 20'd123456) begin
            miscompares++;
            $display("FAIL both_cmd: digits=%h cursor=%0d value=%0d, expected 0 0 123456",
                     digits, cursor, value);
        end
        set_mode(1'b0);
        press(1);
        press(1);
        repeat (3) press(0);
        press_both();
        vectors++;
        $display("both edit: digits=%h cursor=%0d", digits, cursor);
        if (digits !== to_bcd(400) || cursor !== 3'd3) begin
            miscompares++;
            $display("FAIL both_edit: digits=%h cursor=%0d, expected %h and 3", digits, cursor, to_bcd(400));
        end
    endtask

    task automatic test_max();
        clear_all();
        enter_number(999999);
        set_mode(1'b1);
        sb.push_back(20'd999999);
        press(0);
        wait_drain("max");
        vectors++;
        if (value !== 20'hF423F) begin
            miscompares++;
            $display("FAIL max_value: value=%h, expected f423f", value);
        end
    endtask

    task automatic test_reset_mid_convert();
        bit seen;
        clear_all();
        enter_number(42);
        set_mode(1'b1);
        key_n[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (busy === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL abort_busy: busy=%b, expected 1 within 30 cycles", busy);
        end
        repeat (2) tick();
        key_n = 2'b11;
        rst_n = 1'b0;
        busy_run = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        vectors++;
        $display("abort: value=%0d busy=%b digits=%h", value, busy, digits);
        if (value !== '0 || busy !== 1'b0 || digits !== '0 || cursor !== 3'd0) begin
            miscompares++;
            $display("FAIL abort: value=%0d busy=%b digits=%h cursor=%0d, expected all 0",
                     value, busy, digits, cursor);
        end
    endtask

    task automatic test_min();
        sb.push_back(20'd0);
        press(0);
        wait_drain("min");
        vectors++;
        if (value !== '0) begin
            miscompares++;
            $display("FAIL min_value: value=%0d, expected 0", value);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_edit_wrap();
        test_commit();
        test_press_during_busy();
        test_simultaneous();
        test_max();
        test_reset_mid_convert();
        test_min();
        repeat (10) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
